icache_assoc: RTL
=================

Name: icache_assoc

Overview:
Parametrised set-associative instruction cache that replaces the fixed 512 B direct-mapped fetch cache. It returns a full line to the fetch stage on a hit. On a miss it owns a miss FSM that issues one line-fill request to the memory/bus side and writes the returned line into an LRU-selected way. It adds three things the old cache lacked: reset-cleared valid bits, a multi-cycle flush (invalidate-all) sequence, and fill-error reporting.

Parameters:
NUM_SETS, 16, number of sets; power of 2, ≥2; IDX_W = log2(NUM_SETS).
WAYS, 2, associativity; legal values 1 or 2.
LINE_BYTES, 32, line size in bytes; power of 2; OFF_W = log2(LINE_BYTES).
PA_W, 15, physical address width used by the cache; TAG_W = PA_W − IDX_W − OFF_W.

Ports:
clk  in  1  clock. One clock; reset is synchronous and active-high.
rst  in  1  synchronous active-high reset.
ren  in  1  fetch read request.
addr  in  PA_W  fetch physical address.
ic_exp  in  1  exception/kill; suppresses hit, miss and miss-start this cycle.
flush  in  1  request to invalidate all lines.
r_data  out  LINE_BYTES*8  line data of the hitting way.
ic_hit  out  1  hit this cycle.
ic_miss  out  1  miss this cycle.
busy  out  1  FSM not in IDLE.
mem_req  out  1  line-fill request.
mem_addr  out  PA_W  line-aligned fill address; low OFF_W bits are 0.
mem_ack  in  1  fill response valid; single-cycle pulse.
mem_data  in  LINE_BYTES*8  fill line.
mem_err  in  1  fill error; qualified by mem_ack.
fill_err  out  1  one-cycle pulse on an errored fill.

Behaviour:
- Address split: offset = addr[OFF_W-1:0] (ignored); index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[PA_W-1:OFF_W+IDX_W].
- Storage is flop/latch arrays: per way, NUM_SETS × (valid, tag, line). One LRU bit per set when WAYS=2.
- Lookup is combinational, same cycle. way_hit[w] = valid[w][index] & (tag[w][index] == tag). r_data = line of the hitting way. With no hit, r_data = way0 line.
- ic_hit = ren & ~ic_exp & IDLE & ~flush & |way_hit.
- ic_miss = ren & ~ic_exp & IDLE & ~flush & ~|way_hit.
- Both ic_hit and ic_miss are 0 whenever busy=1.
- On a hit, at the clock edge, lru[index] ← index of the non-hitting way (WAYS=2 only).
- FSM states: IDLE, REQ, FLUSH.
- IDLE → FLUSH when flush=1; flush has priority over ren.
- IDLE → REQ when ic_miss=1. At that edge, latch miss_addr = {tag, index, OFF_W'b0}.
- REQ: mem_req=1 and mem_addr=miss_addr, held stable until mem_ack. mem_req is deasserted in the cycle after mem_ack.
- REQ, mem_ack & ~mem_err: write mem_data and tag into the victim way, set valid=1, set lru[set] = other way, go to IDLE. The fetch re-issues and hits at the earliest on the next cycle.
- Victim selection: first invalid way, way0 preferred; otherwise the way pointed to by lru. With WAYS=1, always way0.
- REQ, mem_ack & mem_err: no array write, fill_err=1 for that single cycle, go to IDLE.
- mem_ack outside REQ is ignored.
- flush while in REQ sets flush_pend. After the fill completes (written or errored), the FSM goes to FLUSH instead of IDLE. A completed fill is therefore flushed too.
- FLUSH: an IDX_W-bit counter starts at 0. Each cycle it clears valid for all ways and the LRU bit of set[counter]. When counter = NUM_SETS−1 the FSM returns to IDLE and the counter returns to 0. Duration is NUM_SETS cycles; flush_pend clears on FLUSH entry. flush asserted during FLUSH is absorbed, with no restart.
- Reset, from any state including mid-REQ or mid-FLUSH:
  - state=IDLE; all valid=0, all lru=0, counter=0, flush_pend=0.
  - mem_req=0, mem_addr=0, fill_err=0, ic_hit=0, ic_miss=0, busy=0.
  - Tag and data arrays are not cleared.
  - An outstanding fill is abandoned; its later mem_ack is ignored.
- ic_exp asserted during REQ does not cancel the outstanding fill.

Test Plan:
Defaults (16 sets, 2 ways, 32 B lines, PA_W=15):
- Reset, then ren=1, addr=0x1234 → ic_miss=1, ic_hit=0. Next cycle: mem_req=1, mem_addr=0x1220, busy=1, ic_miss=0.
- Continuing: mem_ack=1, mem_data=pattern A → next cycle IDLE. ren at 0x1234 → ic_hit=1, r_data=A; valid[0][1]=1, tag=0x09.
- Fill 0x1220 (way0), then 0x3220 (way1, same set 1), hit 0x1220, then miss 0x5220 → victim is way1; a later 0x1220 still hits, 0x3220 misses.
- During REQ for 0x0040: assert flush; return mem_ack with mem_err=1 → fill_err pulses 1 cycle, no write, FSM enters FLUSH for exactly 16 cycles, then ic_miss on any prior line.
- flush=1 and ren=1 in the same IDLE cycle on a valid line → ic_hit=0, ic_miss=0, busy=1 next cycle.
- rst=1 mid-REQ, then mem_ack pulse → ignored: mem_req=0, all lookups miss.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways) with LRU
// replacement, a single-request miss FSM, multi-cycle invalidate-all flush
// and fill-error reporting.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ren, addr, ic_exp     fetch request, physical address, kill for this cycle
//   flush                 invalidate-all request
//   r_data, ic_hit,       hitting line, same-cycle hit/miss indication
//   ic_miss, busy         busy = FSM not idle
//   mem_req, mem_addr     line-fill request and line-aligned fill address
//   mem_ack, mem_data,    fill response (one-cycle pulse), line, error flag
//   mem_err
//   fill_err              one-cycle pulse on an errored fill
module icache_assoc #(
  parameter int NUM_SETS   = 16,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 32,
  parameter int PA_W       = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ren,
  input  logic [PA_W-1:0]           addr,
  input  logic                      ic_exp,
  input  logic                      flush,
  output logic [LINE_BYTES*8-1:0]   r_data,
  output logic                      ic_hit,
  output logic                      ic_miss,
  output logic                      busy,
  output logic                      mem_req,
  output logic [PA_W-1:0]           mem_addr,
  input  logic                      mem_ack,
  input  logic [LINE_BYTES*8-1:0]   mem_data,
  input  logic                      mem_err,
  output logic                      fill_err
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = PA_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FLUSH} state_t;

  state_t               state, state_nxt;
  logic [NUM_SETS-1:0]  valid    [WAYS];
  logic [TAG_W-1:0]     tag_arr  [WAYS][NUM_SETS];
  logic [LINE_W-1:0]    data_arr [WAYS][NUM_SETS];
  logic [NUM_SETS-1:0]  lru;

  logic [IDX_W-1:0]     idx, miss_idx, flush_cnt;
  logic [TAG_W-1:0]     tag, miss_tag;
  logic [PA_W-1:0]      miss_addr;
  logic                 flush_pend;
  logic [WAYS-1:0]      way_hit;
  logic                 hit_way, victim;
  logic                 lookup, fill_ok;
  logic                 unused_off;

  assign idx        = addr[OFF_W+IDX_W-1:OFF_W];
  assign tag        = addr[PA_W-1:OFF_W+IDX_W];
  assign miss_idx   = miss_addr[OFF_W+IDX_W-1:OFF_W];
  assign miss_tag   = miss_addr[PA_W-1:OFF_W+IDX_W];
  assign unused_off = ^addr[OFF_W-1:0];

  always_comb begin
    way_hit = '0;
    hit_way = 1'b0;
    r_data  = data_arr[0][idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_hit[w] = valid[w][idx] && (tag_arr[w][idx] == tag);
      if (way_hit[w]) begin
        r_data  = data_arr[w][idx];
        hit_way = w[0];
      end
    end
  end

  assign lookup   = ren & ~ic_exp & ~flush & (state == ST_IDLE);
  assign ic_hit   = lookup & (|way_hit);
  assign ic_miss  = lookup & ~(|way_hit);
  assign busy     = (state != ST_IDLE);
  assign mem_req  = (state == ST_REQ);
  assign mem_addr = mem_req ? miss_addr : '0;
  assign fill_ok  = mem_req & mem_ack & ~mem_err;
  assign fill_err = mem_req & mem_ack & mem_err;

  // Victim: first invalid way (way0 preferred), else the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (valid[0][miss_idx])
        victim = valid[WAYS-1][miss_idx] ? lru[miss_idx] : 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush)        state_nxt = ST_FLUSH;
        else if (ic_miss) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A flush seen during the fill (now or earlier) runs after it.
        if (mem_ack) state_nxt = (flush_pend || flush) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_cnt == IDX_W'(NUM_SETS - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      miss_addr  <= '0;
      lru        <= '0;
      for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      state <= state_nxt;
      if (ic_miss) miss_addr <= {tag, idx, {OFF_W{1'b0}}};

      if (state == ST_REQ && flush) flush_pend <= 1'b1;
      if (state_nxt == ST_FLUSH)    flush_pend <= 1'b0;

      if (state == ST_FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
        lru[flush_cnt] <= 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) valid[w][flush_cnt] <= 1'b0;
      end else begin
        flush_cnt <= '0;
      end

      if (ic_hit && WAYS == 2) lru[idx] <= ~hit_way;

      if (fill_ok) begin
        valid[victim][miss_idx] <= 1'b1;
        if (WAYS == 2) lru[miss_idx] <= ~victim;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_ok && !rst) begin
      tag_arr[victim][miss_idx]  <= miss_tag;
      data_arr[victim][miss_idx] <= mem_data;
    end
  end

endmodule
